// File: rtl/dcache_assoc.sv
// -----------------------------------------------------------------------------
// dcache_assoc
// Set-associative, write-back, write-allocate data cache between the MEM
// stage and a synchronous data memory (read data returns one cycle after
// mrden). Hits complete combinationally. Misses stall the pipeline through
// data_ready. A miss may first write back a dirty victim, then fills the line.
// A level-sensitive flush walks every line, writes back the dirty ones and
// invalidates the whole cache.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   address        : CPU byte address (bits [1:0] ignored)
//   data_in_cpu    : store data
//   rd             : load request
//   wr             : store byte enables (non-zero = store, overrides rd)
//   flush          : flush request (level)
//   data2cpu       : load data, valid while data_ready and rd
//   data_ready     : request completes this cycle / nothing pending
//   flush_busy     : flush walk in progress
//   m_rd_address   : memory read byte address (word aligned)
//   m_wr_address   : memory write byte address (word aligned)
//   mrden, mwren   : memory read / write strobes (never both high)
//   data2mem       : memory write data
//   data_in_mem    : memory read data
// -----------------------------------------------------------------------------
module dcache_assoc #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in_cpu,
    input  logic              rd,
    input  logic [3:0]        wr,
    input  logic              flush,
    output logic [DATA_W-1:0] data2cpu,
    output logic              data_ready,
    output logic              flush_busy,
    output logic [ADDR_W-1:0] m_rd_address,
    output logic [ADDR_W-1:0] m_wr_address,
    output logic              mrden,
    output logic              mwren,
    output logic [DATA_W-1:0] data2mem,
    input  logic [DATA_W-1:0] data_in_mem
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IX_W  = $clog2(SETS);
    localparam int WY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IX_W;
    localparam int CNT_W = OFF_W + 1;

    typedef enum logic [1:0] {IDLE, WB, FILL, FLUSH} state_t;

    // Address fields
    logic [OFF_W-1:0] word_sel;
    logic [IX_W-1:0]  set_sel;
    logic [TAG_W-1:0] tag_sel;
    logic             unused_byte_bits;

    assign word_sel         = address[2 +: OFF_W];
    assign set_sel          = address[2+OFF_W +: IX_W];
    assign tag_sel          = address[ADDR_W-1 -: TAG_W];
    assign unused_byte_bits = ^address[1:0];

    // Line storage
    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS][LINE_WORDS];
    logic [WY_W-1:0]   ptr_q   [SETS];

    // Controller state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WY_W-1:0]  vic_q, vic_d;
    logic [IX_W-1:0]  fl_set_q, fl_set_d;
    logic [WY_W-1:0]  fl_way_q, fl_way_d;

    logic             store, req;
    logic             hit;
    logic [WY_W-1:0]  hit_way;
    logic             inv_found;
    logic [WY_W-1:0]  inv_way;
    logic [WY_W-1:0]  victim;
    logic [OFF_W-1:0] cnt_word;
    logic [OFF_W-1:0] cap_word;
    logic             fl_dirty;
    logic             fl_last;

    logic do_store, do_capture, do_fill_done, do_inval;

    assign store    = |wr;
    assign req      = store | rd;
    assign cnt_word = cnt_q[OFF_W-1:0];
    // FILL cycle k captures the word requested in cycle k-1
    assign cap_word = OFF_W'(cnt_q - CNT_W'(1));
    assign fl_dirty = valid_q[fl_set_q][fl_way_q] && dirty_q[fl_set_q][fl_way_q];
    assign fl_last  = (fl_set_q == IX_W'(SETS-1)) && (fl_way_q == WY_W'(WAYS-1));

    // Tag compare and victim choice for the requested set
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_sel][w] && (tag_q[set_sel][w] == tag_sel)) begin
                hit     = 1'b1;
                hit_way = WY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!valid_q[set_sel][w]) begin
                inv_found = 1'b1;
                inv_way   = WY_W'(w);
            end
        end
        victim = inv_found ? inv_way : ptr_q[set_sel];
    end

    // Next state and outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vic_d        = vic_q;
        fl_set_d     = fl_set_q;
        fl_way_d     = fl_way_q;
        data_ready   = 1'b0;
        data2cpu     = '0;
        flush_busy   = 1'b0;
        mrden        = 1'b0;
        mwren        = 1'b0;
        m_rd_address = '0;
        m_wr_address = '0;
        data2mem     = '0;
        do_store     = 1'b0;
        do_capture   = 1'b0;
        do_fill_done = 1'b0;
        do_inval     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    // Flush wins; a concurrent request is held and served later
                    state_d  = FLUSH;
                    cnt_d    = '0;
                    fl_set_d = '0;
                    fl_way_d = '0;
                end else if (!req) begin
                    data_ready = 1'b1;
                end else if (hit) begin
                    data_ready = 1'b1;
                    data2cpu   = data_q[set_sel][hit_way][word_sel];
                    do_store   = store;
                end else begin
                    vic_d = victim;
                    cnt_d = '0;
                    if (valid_q[set_sel][victim] && dirty_q[set_sel][victim])
                        state_d = WB;
                    else
                        state_d = FILL;
                end
            end

            WB: begin
                mwren        = 1'b1;
                m_wr_address = {tag_q[set_sel][vic_q], set_sel, cnt_word, 2'b00};
                data2mem     = data_q[set_sel][vic_q][cnt_word];
                if (cnt_q == CNT_W'(LINE_WORDS-1)) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            FILL: begin
                if (cnt_q != CNT_W'(LINE_WORDS)) begin
                    mrden        = 1'b1;
                    m_rd_address = {tag_sel, set_sel, cnt_word, 2'b00};
                end
                do_capture = (cnt_q != '0);
                if (cnt_q == CNT_W'(LINE_WORDS)) begin
                    do_fill_done = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            FLUSH: begin
                flush_busy = 1'b1;
                if (fl_dirty) begin
                    mwren        = 1'b1;
                    m_wr_address = {tag_q[fl_set_q][fl_way_q], fl_set_q, cnt_word, 2'b00};
                    data2mem     = data_q[fl_set_q][fl_way_q][cnt_word];
                end
                if (!fl_dirty || (cnt_q == CNT_W'(LINE_WORDS-1))) begin
                    do_inval = 1'b1;
                    cnt_d    = '0;
                    if (fl_last) begin
                        state_d = IDLE;
                    end else if (fl_way_q == WY_W'(WAYS-1)) begin
                        fl_way_d = '0;
                        fl_set_d = fl_set_q + 1'b1;
                    end else begin
                        fl_way_d = fl_way_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, valid/dirty bits, replacement pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vic_q    <= '0;
            fl_set_q <= '0;
            fl_way_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vic_q    <= vic_d;
            fl_set_q <= fl_set_d;
            fl_way_q <= fl_way_d;
            if (do_store)
                dirty_q[set_sel][hit_way] <= 1'b1;
            if (do_fill_done) begin
                valid_q[set_sel][vic_q] <= 1'b1;
                dirty_q[set_sel][vic_q] <= 1'b0;
                ptr_q[set_sel] <= (ptr_q[set_sel] == WY_W'(WAYS-1)) ? '0
                                                                    : ptr_q[set_sel] + 1'b1;
            end
            if (do_inval) begin
                valid_q[fl_set_q][fl_way_q] <= 1'b0;
                dirty_q[fl_set_q][fl_way_q] <= 1'b0;
                ptr_q[fl_set_q]             <= '0;
            end
        end
    end

    // Data and tag arrays: written only by a hit store or a fill
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (wr[b])
                    data_q[set_sel][hit_way][word_sel][b*8 +: 8] <= data_in_cpu[b*8 +: 8];
            end
        end
        if (do_capture)
            data_q[set_sel][vic_q][cap_word] <= data_in_mem;
        if (do_fill_done)
            tag_q[set_sel][vic_q] <= tag_sel;
    end

endmodule

// File: tb/tb_dcache_assoc.sv
module tb_dcache_assoc;

    logic        clk;
    logic        rst;
    logic [15:0] address;
    logic [31:0] data_in_cpu;
    logic        rd;
    logic [3:0]  wr;
    logic        flush;
    logic [31:0] data2cpu;
    logic        data_ready;
    logic        flush_busy;
    logic [15:0] m_rd_address;
    logic [15:0] m_wr_address;
    logic        mrden;
    logic        mwren;
    logic [31:0] data2mem;
    logic [31:0] data_in_mem;

    int checks = 0;
    int errors = 0;

    dcache_assoc #(
        .ADDR_W(16), .DATA_W(32), .SETS(16), .WAYS(2), .LINE_WORDS(4)
    ) dut (
        .clk(clk), .rst(rst), .address(address), .data_in_cpu(data_in_cpu),
        .rd(rd), .wr(wr), .flush(flush), .data2cpu(data2cpu),
        .data_ready(data_ready), .flush_busy(flush_busy),
        .m_rd_address(m_rd_address), .m_wr_address(m_wr_address),
        .mrden(mrden), .mwren(mwren), .data2mem(data2mem),
        .data_in_mem(data_in_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory model with strobe logging
    logic [31:0] mem [16384];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [15:0] rd_log [64];
    logic [15:0] wa_log [64];
    logic [31:0] wd_log [64];
    logic        both_strobes = 1'b0;

    always @(posedge clk) begin
        if (mrden) begin
            data_in_mem          <= mem[m_rd_address[15:2]];
            rd_log[rd_cnt % 64]  <= m_rd_address;
            rd_cnt               <= rd_cnt + 1;
        end
        if (mwren) begin
            mem[m_wr_address[15:2]] <= data2mem;
            wa_log[wr_cnt % 64]     <= m_wr_address;
            wd_log[wr_cnt % 64]     <= data2mem;
            wr_cnt                  <= wr_cnt + 1;
        end
        if (mrden && mwren)
            both_strobes <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until data_ready, return stall count and load data
    task automatic access(input logic is_rd, input logic [3:0] be, input logic [15:0] a,
                          input logic [31:0] d, output int stall, output logic [31:0] q);
        logic done;
        address     = a;
        data_in_cpu = d;
        if (is_rd) rd = 1'b1; else wr = be;
        stall = 0;
        done  = 1'b0;
        q     = '0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (data_ready) begin
                done = 1'b1;
                q    = data2cpu;
            end else begin
                stall++;
            end
            @(posedge clk);
            #1;
        end
        rd = 1'b0;
        wr = 4'b0000;
        if (!done) check("access_timeout", 32'd0, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a,
                          input int exp_stall, input logic [31:0] exp_data);
        int          st;
        logic [31:0] q;
        access(1'b1, 4'b0000, a, 32'd0, st, q);
        check({tag, "_stall"}, 32'(st), 32'(exp_stall));
        check({tag, "_data"}, q, exp_data);
    endtask

    // Run a flush to completion; returns number of flush_busy cycles
    task automatic run_flush(output int busy);
        logic done;
        busy = 0;
        done = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_req_not_ready", {31'd0, data_ready}, 32'd0);
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!flush_busy) done = 1'b1;
            else busy++;
        end
        flush = 1'b0;
        if (!done) check("flush_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          st, busy, r0, w0;
        logic [31:0] q;

        for (int i = 0; i < 16384; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
        mem[16'h0040 >> 2] = 32'hA5A5_0001;
        data_in_mem = '0;
        rst = 1'b1; address = '0; data_in_cpu = '0; rd = 1'b0; wr = 4'b0000; flush = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mrden", {31'd0, mrden}, 32'd0);
        check("rst_mwren", {31'd0, mwren}, 32'd0);
        check("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
        check("rst_data2mem", data2mem, 32'd0);
        check("rst_m_rd_address", {16'd0, m_rd_address}, 32'd0);
        check("rst_m_wr_address", {16'd0, m_wr_address}, 32'd0);
        check("rst_data_ready", {31'd0, data_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: clean miss then hit
        r0 = rd_cnt;
        rd_chk("s1_miss", 16'h0040, 6, 32'hA5A5_0001);
        check("s1_mrden_count", 32'(rd_cnt - r0), 32'd4);
        check("s1_first_rd_addr", {16'd0, rd_log[r0 % 64]}, 32'h0040);
        check("s1_last_rd_addr", {16'd0, rd_log[(r0 + 3) % 64]}, 32'h004C);
        r0 = rd_cnt;
        rd_chk("s1_hit", 16'h0044, 0, 32'hC0DE_0044);
        check("s1_hit_no_mrden", 32'(rd_cnt - r0), 32'd0);

        // 2: byte store merge
        r0 = rd_cnt; w0 = wr_cnt;
        access(1'b0, 4'b0010, 16'h0040, 32'h0000_BB00, st, q);
        check("s2_store_stall", 32'(st), 32'd0);
        rd_chk("s2_merged", 16'h0040, 0, 32'hA5A5_BB01);
        check("s2_no_mem_rd", 32'(rd_cnt - r0), 32'd0);
        check("s2_no_mem_wr", 32'(wr_cnt - w0), 32'd0);

        // 3: eviction with write-back of the dirty 0x0040 line
        rd_chk("s3_fill_way1", 16'h0140, 6, 32'hC0DE_0140);
        r0 = rd_cnt; w0 = wr_cnt;
        rd_chk("s3_evict", 16'h0240, 10, 32'hC0DE_0240);
        check("s3_mwren_count", 32'(wr_cnt - w0), 32'd4);
        check("s3_wb_addr0", {16'd0, wa_log[w0 % 64]}, 32'h0040);
        check("s3_wb_addr3", {16'd0, wa_log[(w0 + 3) % 64]}, 32'h004C);
        check("s3_wb_data0", wd_log[w0 % 64], 32'hA5A5_BB01);
        check("s3_mrden_count", 32'(rd_cnt - r0), 32'd4);
        check("s3_fill_addr0", {16'd0, rd_log[r0 % 64]}, 32'h0240);
        rd_chk("s3_way1_kept", 16'h0144, 0, 32'hC0DE_0144);

        // 4: flush with one dirty line
        access(1'b0, 4'b1111, 16'h0144, 32'h1234_5678, st, q);
        check("s4_store_stall", 32'(st), 32'd0);
        w0 = wr_cnt;
        run_flush(busy);
        check("s4_busy_cycles", 32'(busy), 32'd35);
        check("s4_mwren_count", 32'(wr_cnt - w0), 32'd4);
        check("s4_wb_addr0", {16'd0, wa_log[w0 % 64]}, 32'h0140);
        rd_chk("s4_miss_a", 16'h0240, 6, 32'hC0DE_0240);
        rd_chk("s4_miss_b", 16'h0144, 6, 32'h1234_5678);

        // 5: flush and read raised together
        r0 = rd_cnt; w0 = wr_cnt;
        rd = 1'b1;
        address = 16'h0340;
        run_flush(busy);
        check("s5_busy_cycles", 32'(busy), 32'd32);
        check("s5_no_rd_during_flush", 32'(rd_cnt - r0), 32'd0);
        check("s5_no_wr_clean_flush", 32'(wr_cnt - w0), 32'd0);
        rd_chk("s5_read_after", 16'h0340, 6, 32'hC0DE_0340);
        check("s5_mrden_count", 32'(rd_cnt - r0), 32'd4);

        // 6: reset during FILL cycle 2
        address = 16'h0440;
        rd = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("s6_fill_mrden", {31'd0, mrden}, 32'd1);
        rst = 1'b1;
        #1;
        check("s6_rst_mrden", {31'd0, mrden}, 32'd0);
        check("s6_rst_not_ready", {31'd0, data_ready}, 32'd0);
        rd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_chk("s6_miss_again", 16'h0440, 6, 32'hC0DE_0440);
        rd_chk("s6_other_lost", 16'h0340, 6, 32'hC0DE_0340);

        check("strobe_exclusive", {31'd0, both_strobes}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
